axi_burst_master: RTL and testbench
===================================

Name: axi_burst_master

Overview:
- Parametrised AXI4 master bridge between one CPU-side memory port (IM or DM) and the AXI interconnect.
- Next generation of the single-beat master: adds INCR bursts of 1..2^LEN_W beats, per-beat streaming, a configurable transaction ID, and response/protocol error reporting.
- The CPU wrapper instantiates one per port; IM instances tie write inputs low.

Parameters:
- ID_W, 4, AXI ID width.
- MASTER_ID, 0, constant driven on ARID/AWID and checked on RID/BID.
- ADDR_W, 32, address width.
- DATA_W, 32, data width; STRB_W = DATA_W/8.
- LEN_W, 4, burst-length field width; max burst is 2^LEN_W beats.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  CPU request; held until done.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  start address, DATA_W/8-aligned.
- req_len  in  LEN_W  beats-1.
- stall  out  1  CPU must hold request and pipeline.
- done  out  1  one-cycle completion pulse.
- resp_err  out  1  valid with done; 1 if any error seen.
- rbeat_valid  out  1  read beat available.
- rbeat_data  out  DATA_W  read beat data.
- wbeat_valid  in  1  CPU write beat present.
- wbeat_data  in  DATA_W  write beat data.
- wbeat_strb  in  STRB_W  write beat byte strobes.
- wbeat_ready  out  1  write beat consumed this cycle.
- AR channel: ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID (out); ARREADY (in).
- R channel: RID, RDATA, RRESP, RLAST, RVALID (in); RREADY (out).
- AW channel: AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID (out); AWREADY (in).
- W channel: WDATA, WSTRB, WLAST, WVALID (out); WREADY (in).
- B channel: BID, BRESP, BVALID (in); BREADY (out).
- AXI field widths: LEN = LEN_W zero-extended to 8 bits; SIZE = 3; BURST = 2.

Behaviour:
- Reset: state IDLE; all VALID/READY outputs 0, done 0, resp_err 0, beat counter 0, error flag 0. Address/len registers cleared to 0.
- FSM states: IDLE, AR, R, AW, W, B, DONE.
- IDLE, req_valid=1: latch addr, len and write. Next state AW if write, else AR. Clear error flag.
- Stall: combinationally 1 in IDLE when req_valid=1, and 1 in every state except IDLE and DONE.
- AR/AW: VALID asserted from the state's first cycle and held with stable fields until READY. Field values: ADDR = latched addr, LEN = latched len, SIZE = log2(STRB_W), BURST = INCR(2'b01). On handshake go to R or W.
- R:
  - RREADY = 1.
  - Each RVALID beat: rbeat_valid = 1, rbeat_data = RDATA (combinational pass-through); counter increments.
  - Error flag set if: RRESP != 0, RID != MASTER_ID, RLAST arrives before counter == len, or counter == len without RLAST.
  - Leave R on the beat where counter == len or RLAST, whichever comes first. Go to DONE.
- W:
  - WVALID = wbeat_valid; WDATA/WSTRB pass through; WLAST = (counter == len).
  - wbeat_ready = WVALID && WREADY; counter increments on it.
  - W is never driven before the AW handshake completes.
  - After the last beat go to B.
- B: BREADY = 1. On BVALID, set error flag if BRESP != 0 or BID != MASTER_ID. Go to DONE.
- DONE: one cycle. done = 1, stall = 0, resp_err = error flag; counter cleared. Next state IDLE. The CPU drops or changes req_valid on the following edge.
- Latency: single-beat read with zero-wait slave = 4 cycles from req_valid to done (IDLE, AR, R, DONE).
- req_len = 0 means 1 beat. req_len = 2^LEN_W-1 means max burst; the counter is LEN_W+1 bits, so there is no wrap.
- 4KB-boundary legality is the requester's responsibility. The bench asserts it; RTL does not split bursts.
- req input changes while not IDLE are ignored (latched copy used).
- rst asserted mid-transaction: next cycle all VALID/READY outputs are 0 and state is IDLE, with no done pulse. The interconnect is reset together.

Decomposition:
- Package axi_master_pkg holds:
  - BURST_INCR and RESP_OKAY/EXOKAY/SLVERR/DECERR constants.
  - typedef enum logic [2:0] state_t.
  - function size_from_bytes().
- One sub-module, axi_beat_counter: LEN_W+1-bit counter with clear, inc and is_last compare against len. Shared by the R and W paths.

Test Plan:
- Single read: req_addr=0x100, len=0, slave RDATA=0xDEADBEEF with RLAST, zero wait.
  -> ARADDR=0x100, ARLEN=0; rbeat_data=0xDEADBEEF; done at cycle 4, resp_err=0.
- 4-beat read: len=3, slave inserts 2 wait cycles between beats.
  -> exactly 4 rbeat_valid pulses in order; RLAST on the 4th; done next cycle.
- 8-beat write: len=7, CPU deasserts wbeat_valid on beat 3 for 3 cycles, WREADY toggling.
  -> WLAST only on beat 8; no WVALID before AW handshake; done after BVALID; WSTRB mirrors input.
- Errors, three cases:
  - BRESP=SLVERR -> resp_err=1.
  - Early RLAST on beat 2 of len=3 -> resp_err=1, done follows.
  - RID=5 with MASTER_ID=1 -> resp_err=1.
- Reset mid-burst: assert rst during R beat 2 of len=3.
  -> RREADY/ARVALID 0 next cycle, stall 0 with req_valid low, no done. A new read then completes normally.
- Back-to-back: write, then read issued the cycle after done.
  -> read AR starts 1 cycle after IDLE; the error flag does not carry over from the prior transaction.

Source files
------------

// File: rtl/axi_master_pkg.sv
// Shared constants and types for the AXI4 burst master.
// Holds response codes, the FSM state type and the SIZE helper.
package axi_master_pkg;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_AW,
    S_W,
    S_B,
    S_DONE
  } state_t;

  function automatic logic [2:0] size_from_bytes(input int unsigned bytes);
    logic [2:0] s;
    s = '0;
    for (int i = 0; i < 8; i++)
      if (bytes == (32'd1 << i)) s = 3'(i);
    return s;
  endfunction

endpackage

// File: rtl/axi_beat_counter.sv
// Beat counter shared by the read and write data paths.
// One bit wider than len so a full 2^LEN_W burst never wraps.
module axi_beat_counter #(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [LEN_W-1:0] len,
  output logic             is_last
);

  logic [LEN_W:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (inc)   cnt <= cnt + 1'b1;
  end

  assign is_last = (cnt == {1'b0, len});

endmodule

// File: rtl/axi_burst_master.sv
// AXI4 INCR-burst master bridging one CPU memory port to the interconnect.
// Beats stream through combinationally; errors are folded into resp_err.
module axi_burst_master
  import axi_master_pkg::*;
#(
  parameter int ID_W      = 4,
  parameter int MASTER_ID = 0,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 4,
  localparam int STRB_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  output logic              stall,
  output logic              done,
  output logic              resp_err,
  output logic              rbeat_valid,
  output logic [DATA_W-1:0] rbeat_data,
  input  logic              wbeat_valid,
  input  logic [DATA_W-1:0] wbeat_data,
  input  logic [STRB_W-1:0] wbeat_strb,
  output logic              wbeat_ready,
  output logic [ID_W-1:0]   ARID,
  output logic [ADDR_W-1:0] ARADDR,
  output logic [7:0]        ARLEN,
  output logic [2:0]        ARSIZE,
  output logic [1:0]        ARBURST,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [ID_W-1:0]   RID,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RLAST,
  input  logic              RVALID,
  output logic              RREADY,
  output logic [ID_W-1:0]   AWID,
  output logic [ADDR_W-1:0] AWADDR,
  output logic [7:0]        AWLEN,
  output logic [2:0]        AWSIZE,
  output logic [1:0]        AWBURST,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [DATA_W-1:0] WDATA,
  output logic [STRB_W-1:0] WSTRB,
  output logic              WLAST,
  output logic              WVALID,
  input  logic              WREADY,
  input  logic [ID_W-1:0]   BID,
  input  logic [1:0]        BRESP,
  input  logic              BVALID,
  output logic              BREADY
);

  localparam logic [ID_W-1:0] MID  = ID_W'(MASTER_ID);
  localparam logic [2:0]      SIZE = size_from_bytes(STRB_W);

  state_t state, nxt;

  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic              err_q;
  logic              is_last;
  logic              r_beat;
  logic              w_beat;
  logic              err_set;

  assign r_beat = (state == S_R) && RVALID;
  assign w_beat = (state == S_W) && wbeat_valid && WREADY;

  axi_beat_counter #(.LEN_W(LEN_W)) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     ((state == S_IDLE) || (state == S_DONE)),
    .inc     (r_beat || w_beat),
    .len     (len_q),
    .is_last (is_last)
  );

  // RLAST must coincide exactly with the final counted beat
  always_comb begin
    err_set = 1'b0;
    if (r_beat)
      err_set = (RRESP != RESP_OKAY) || (RID != MID) ||
                (RLAST != is_last);
    else if ((state == S_B) && BVALID)
      err_set = (BRESP != RESP_OKAY) || (BID != MID);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      len_q  <= '0;
      err_q  <= 1'b0;
    end else if ((state == S_IDLE) && req_valid) begin
      addr_q <= req_addr;
      len_q  <= req_len;
      err_q  <= 1'b0;
    end else if (err_set) begin
      err_q  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: if (req_valid) nxt = req_write ? S_AW : S_AR;
      S_AR:   if (ARREADY) nxt = S_R;
      S_R:    if (RVALID && (is_last || RLAST)) nxt = S_DONE;
      S_AW:   if (AWREADY) nxt = S_W;
      S_W:    if (w_beat && is_last) nxt = S_B;
      S_B:    if (BVALID) nxt = S_DONE;
      S_DONE: nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ARVALID     = 1'b0;
    RREADY      = 1'b0;
    AWVALID     = 1'b0;
    WVALID      = 1'b0;
    BREADY      = 1'b0;
    done        = 1'b0;
    resp_err    = 1'b0;
    rbeat_valid = 1'b0;
    stall       = 1'b1;
    unique case (state)
      S_IDLE: stall = req_valid;
      S_AR:   ARVALID = 1'b1;
      S_R: begin
        RREADY      = 1'b1;
        rbeat_valid = RVALID;
      end
      S_AW:   AWVALID = 1'b1;
      S_W:    WVALID = wbeat_valid;
      S_B:    BREADY = 1'b1;
      S_DONE: begin
        stall    = 1'b0;
        done     = 1'b1;
        resp_err = err_q;
      end
      default: stall = 1'b0;
    endcase
  end

  assign wbeat_ready = WVALID && WREADY;
  assign WLAST       = (state == S_W) && is_last;
  assign WDATA       = wbeat_data;
  assign WSTRB       = wbeat_strb;
  assign rbeat_data  = RDATA;

  assign ARID    = MID;
  assign ARADDR  = addr_q;
  assign ARLEN   = 8'(len_q);
  assign ARSIZE  = SIZE;
  assign ARBURST = BURST_INCR;
  assign AWID    = MID;
  assign AWADDR  = addr_q;
  assign AWLEN   = 8'(len_q);
  assign AWSIZE  = SIZE;
  assign AWBURST = BURST_INCR;

endmodule

// File: tb/tb_axi_burst_master.sv
// Randomized bench for axi_burst_master with a cycle-level AXI slave
// and CPU model; expectations come from transaction-level rules.
module tb_axi_burst_master;

  localparam int MID = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write;
  logic [31:0] req_addr;
  logic [3:0]  req_len;
  logic        stall, done, resp_err;
  logic        rbeat_valid;
  logic [31:0] rbeat_data;
  logic        wbeat_valid;
  logic [31:0] wbeat_data;
  logic [3:0]  wbeat_strb;
  logic        wbeat_ready;
  logic [3:0]  ARID, RID, AWID, BID;
  logic [31:0] ARADDR, AWADDR, RDATA, WDATA;
  logic [7:0]  ARLEN, AWLEN;
  logic [2:0]  ARSIZE, AWSIZE;
  logic [1:0]  ARBURST, AWBURST, RRESP, BRESP;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY;
  logic [3:0]  WSTRB;
  logic        BVALID, BREADY;

  int nchecks = 0;
  int nerrors = 0;

  always #5 clk = ~clk;

  axi_burst_master #(
    .ID_W(4), .MASTER_ID(MID), .ADDR_W(32), .DATA_W(32), .LEN_W(4)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .stall(stall), .done(done), .resp_err(resp_err),
    .rbeat_valid(rbeat_valid), .rbeat_data(rbeat_data),
    .wbeat_valid(wbeat_valid), .wbeat_data(wbeat_data),
    .wbeat_strb(wbeat_strb), .wbeat_ready(wbeat_ready),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
    .RVALID(RVALID), .RREADY(RREADY),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID),
    .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  // Read transaction: slave model plus per-cycle expectations
  task automatic run_read(
    input logic [31:0] addr, input int len, input int gap,
    input bit ar_rand, input int rid, input int early, input int bad,
    input bit nolast, input logic [31:0] base,
    output int done_cyc, output int rb_cnt, output logic err);
    int cyc, sent, gapc, last_cyc, exp_beats, eff_early;
    bit ar_seen, fin, exp_done, exp_arv, exp_err;
    logic [31:0] exp_data;
    eff_early = nolast ? -1 : early;
    exp_beats = (eff_early >= 0 && eff_early < len) ? eff_early + 1 : len + 1;
    exp_err = (rid != MID) || (bad >= 0 && bad < exp_beats) ||
              (eff_early >= 0 && eff_early < len) || nolast;
    assert (int'(addr & 32'hFFF) + (len + 1) * 4 <= 4096)
      else $error("burst crosses 4KB");
    cyc = 0; sent = 0; gapc = 0; last_cyc = -1; ar_seen = 0; fin = 0;
    done_cyc = -1; rb_cnt = 0; err = 1'bx; exp_data = '0;
    AWREADY = 0; WREADY = 0; BVALID = 0; wbeat_valid = 0;
    while (!fin && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        req_valid = 1; req_write = 0; req_addr = addr; req_len = 4'(len);
      end else if (!exp_done) begin
        req_addr = $urandom; req_len = 4'($urandom);
        req_write = 1'($urandom_range(0, 1));
      end
      ARREADY = ar_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      RVALID = 0; RLAST = 0; RDATA = $urandom;
      RID = 4'($urandom); RRESP = 2'($urandom);
      if (ar_seen && sent < exp_beats) begin
        if (gapc > 0) gapc--;
        else begin
          exp_data = base ^ (32'(sent) * 32'h01010101);
          RVALID = 1; RDATA = exp_data; RID = 4'(rid);
          RRESP = (sent == bad) ? 2'b10 : 2'b00;
          RLAST = nolast ? 1'b0 :
                  (eff_early >= 0 ? sent == eff_early : sent == len);
        end
      end
      #1;
      exp_done = (last_cyc >= 0) && (cyc == last_cyc + 1);
      exp_arv = !ar_seen && cyc >= 2;
      nchecks++;
      if (done !== exp_done) begin
        nerrors++;
        $display("FAIL rd_done cyc%0d: got %b want %b", cyc, done, exp_done);
      end
      nchecks++;
      if (stall !== !exp_done) begin
        nerrors++;
        $display("FAIL rd_stall cyc%0d: got %b want %b", cyc, stall, !exp_done);
      end
      nchecks++;
      if (ARVALID !== exp_arv) begin
        nerrors++;
        $display("FAIL arvalid cyc%0d: got %b want %b", cyc, ARVALID, exp_arv);
      end
      if (exp_arv) begin
        nchecks++;
        if ({ARID, ARADDR, ARLEN, ARSIZE, ARBURST} !==
            {4'(MID), addr, 8'(len), 3'd2, 2'b01}) begin
          nerrors++;
          $display("FAIL ar_fields: got %h %h %h %h %h want %h %h %h 2 1",
                   ARID, ARADDR, ARLEN, ARSIZE, ARBURST, MID, addr, len);
        end
      end
      nchecks++;
      if (RREADY !== (ar_seen && last_cyc < 0)) begin
        nerrors++;
        $display("FAIL rready cyc%0d: got %b want %b", cyc, RREADY,
                 ar_seen && last_cyc < 0);
      end
      nchecks++;
      if (rbeat_valid !== RVALID) begin
        nerrors++;
        $display("FAIL rbeat_valid cyc%0d: got %b want %b", cyc, rbeat_valid, RVALID);
      end
      if (RVALID) begin
        nchecks++;
        if (rbeat_data !== exp_data) begin
          nerrors++;
          $display("FAIL rbeat_data: got %h want %h", rbeat_data, exp_data);
        end
      end
      nchecks++;
      if ({AWVALID, WVALID, BREADY, wbeat_ready} !== 4'b0) begin
        nerrors++;
        $display("FAIL rd_wside: got %b want 0000",
                 {AWVALID, WVALID, BREADY, wbeat_ready});
      end
      if (rbeat_valid) rb_cnt++;
      if (exp_done) begin
        fin = 1; done_cyc = cyc; err = resp_err; req_valid = 0;
        nchecks++;
        if (resp_err !== exp_err) begin
          nerrors++;
          $display("FAIL rd_resp_err: got %b want %b", resp_err, exp_err);
        end
      end
      if (exp_arv && ARREADY) ar_seen = 1;
      if (RVALID) begin
        sent++;
        gapc = (gap < 0) ? $urandom_range(0, 3) : gap;
        if (sent == exp_beats) last_cyc = cyc;
      end
    end
    if (!fin) begin
      nerrors++;
      $display("FAIL rd_timeout: got no done want done");
    end
  endtask

  // Write transaction: CPU beat source, W sink and B responder
  task automatic run_write(
    input logic [31:0] addr, input int len, input bit wr_rand,
    input bit wv_rand, input int hole_beat, input logic [1:0] bresp,
    input int bid, output int done_cyc, output logic err, output int lasts);
    logic [31:0] wd[17];
    logic [3:0]  ws[17];
    int cyc, k, holec, bwait, b_cyc;
    bit aw_seen, fin, exp_done, exp_awv, exp_wv, exp_err;
    for (int i = 0; i < 17; i++) begin
      wd[i] = $urandom; ws[i] = 4'($urandom);
    end
    exp_err = (bresp != 2'b00) || (bid != MID);
    assert (int'(addr & 32'hFFF) + (len + 1) * 4 <= 4096)
      else $error("burst crosses 4KB");
    cyc = 0; k = 0; holec = 0; b_cyc = -1; aw_seen = 0; fin = 0;
    bwait = $urandom_range(0, 2);
    done_cyc = -1; err = 1'bx; lasts = 0;
    ARREADY = 0; RVALID = 0; RLAST = 0;
    while (!fin && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        req_valid = 1; req_write = 1; req_addr = addr; req_len = 4'(len);
      end else if (!exp_done) begin
        req_addr = $urandom; req_len = 4'($urandom);
        req_write = 1'($urandom_range(0, 1));
      end
      AWREADY = wr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      WREADY = wr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (k == hole_beat && holec < 3) begin
        wbeat_valid = 0; holec++;
      end else begin
        wbeat_valid = wv_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      wbeat_data = wd[k]; wbeat_strb = ws[k];
      BVALID = 0; BID = 4'($urandom); BRESP = 2'($urandom);
      if (k > len && b_cyc < 0) begin
        if (bwait > 0) bwait--;
        else begin
          BVALID = 1; BRESP = bresp; BID = 4'(bid);
        end
      end
      #1;
      exp_done = (b_cyc >= 0) && (cyc == b_cyc + 1);
      exp_awv = !aw_seen && cyc >= 2;
      exp_wv = aw_seen && k <= len && wbeat_valid;
      nchecks++;
      if (done !== exp_done) begin
        nerrors++;
        $display("FAIL wr_done cyc%0d: got %b want %b", cyc, done, exp_done);
      end
      nchecks++;
      if (stall !== !exp_done) begin
        nerrors++;
        $display("FAIL wr_stall cyc%0d: got %b want %b", cyc, stall, !exp_done);
      end
      nchecks++;
      if (AWVALID !== exp_awv) begin
        nerrors++;
        $display("FAIL awvalid cyc%0d: got %b want %b", cyc, AWVALID, exp_awv);
      end
      if (exp_awv) begin
        nchecks++;
        if ({AWID, AWADDR, AWLEN, AWSIZE, AWBURST} !==
            {4'(MID), addr, 8'(len), 3'd2, 2'b01}) begin
          nerrors++;
          $display("FAIL aw_fields: got %h %h %h %h %h want %h %h %h 2 1",
                   AWID, AWADDR, AWLEN, AWSIZE, AWBURST, MID, addr, len);
        end
      end
      nchecks++;
      if (WVALID !== exp_wv) begin
        nerrors++;
        $display("FAIL wvalid cyc%0d: got %b want %b", cyc, WVALID, exp_wv);
      end
      nchecks++;
      if (wbeat_ready !== (exp_wv && WREADY)) begin
        nerrors++;
        $display("FAIL wbeat_ready cyc%0d: got %b want %b", cyc,
                 wbeat_ready, exp_wv && WREADY);
      end
      if (exp_wv) begin
        nchecks++;
        if ({WDATA, WSTRB, WLAST} !== {wd[k], ws[k], k == len}) begin
          nerrors++;
          $display("FAIL w_beat%0d: got %h %h %b want %h %h %b", k,
                   WDATA, WSTRB, WLAST, wd[k], ws[k], k == len);
        end
      end
      nchecks++;
      if (BREADY !== (k > len && b_cyc < 0)) begin
        nerrors++;
        $display("FAIL bready cyc%0d: got %b want %b", cyc, BREADY,
                 k > len && b_cyc < 0);
      end
      nchecks++;
      if ({ARVALID, RREADY, rbeat_valid} !== 3'b0) begin
        nerrors++;
        $display("FAIL wr_rside: got %b want 000", {ARVALID, RREADY, rbeat_valid});
      end
      if (WVALID && WREADY && WLAST) lasts++;
      if (exp_done) begin
        fin = 1; done_cyc = cyc; err = resp_err; req_valid = 0;
        wbeat_valid = 0;
        nchecks++;
        if (resp_err !== exp_err) begin
          nerrors++;
          $display("FAIL wr_resp_err: got %b want %b", resp_err, exp_err);
        end
      end
      if (exp_awv && AWREADY) aw_seen = 1;
      if (exp_wv && WREADY) k++;
      if (BVALID) b_cyc = cyc;
    end
    if (!fin) begin
      nerrors++;
      $display("FAIL wr_timeout: got no done want done");
    end
  endtask

  task automatic test_reset();
    rst = 1; req_valid = 0; req_write = 0; req_addr = 0; req_len = 0;
    wbeat_valid = 1; WREADY = 1; RVALID = 1; BVALID = 1;
    ARREADY = 1; AWREADY = 1;
    repeat (3) @(negedge clk);
    #1;
    nchecks++;
    if ({ARVALID, AWVALID, WVALID, RREADY, BREADY} !== 5'b0) begin
      nerrors++;
      $display("FAIL rst_valids: got %b want 00000",
               {ARVALID, AWVALID, WVALID, RREADY, BREADY});
    end
    nchecks++;
    if ({done, resp_err, stall, rbeat_valid, wbeat_ready} !== 5'b0) begin
      nerrors++;
      $display("FAIL rst_cpu: got %b want 00000",
               {done, resp_err, stall, rbeat_valid, wbeat_ready});
    end
    nchecks++;
    if ({ARADDR, ARLEN, AWADDR, AWLEN} !== 80'h0) begin
      nerrors++;
      $display("FAIL rst_regs: got %h %h want 0 0", ARADDR, ARLEN);
    end
    @(negedge clk);
    rst = 0; wbeat_valid = 0; WREADY = 0; RVALID = 0; BVALID = 0;
    ARREADY = 0; AWREADY = 0;
    @(negedge clk);
    #1;
    nchecks++;
    if ({stall, done, ARVALID, AWVALID} !== 4'b0) begin
      nerrors++;
      $display("FAIL idle_quiet: got %b want 0000", {stall, done, ARVALID, AWVALID});
    end
  endtask

  task automatic test_single_read();
    int dc, rb;
    logic e;
    run_read(32'h100, 0, 0, 0, MID, -1, -1, 0, 32'hDEADBEEF, dc, rb, e);
    nchecks++;
    if (dc !== 4 || e !== 1'b0 || rb !== 1) begin
      nerrors++;
      $display("FAIL single_read: got done@%0d err %b beats %0d want 4 0 1", dc, e, rb);
    end
  endtask

  task automatic test_burst_read();
    int dc, rb;
    logic e;
    run_read(32'h2000, 3, 2, 1, MID, -1, -1, 0, $urandom, dc, rb, e);
    nchecks++;
    if (rb !== 4 || e !== 1'b0) begin
      nerrors++;
      $display("FAIL burst_read: got beats %0d err %b want 4 0", rb, e);
    end
  endtask

  task automatic test_burst_write();
    int dc, l;
    logic e;
    run_write(32'h3040, 7, 1, 0, 2, 2'b00, MID, dc, e, l);
    nchecks++;
    if (l !== 1 || e !== 1'b0) begin
      nerrors++;
      $display("FAIL burst_write: got wlast %0d err %b want 1 0", l, e);
    end
  endtask

  task automatic test_errors();
    int dc, rb, l;
    logic e;
    run_write(32'h400, 1, 0, 0, -1, 2'b10, MID, dc, e, l);
    nchecks++;
    if (e !== 1'b1) begin
      nerrors++; $display("FAIL err_bresp: got %b want 1", e);
    end
    run_read(32'h500, 3, 0, 0, MID, 1, -1, 0, $urandom, dc, rb, e);
    nchecks++;
    if (e !== 1'b1 || rb !== 2) begin
      nerrors++; $display("FAIL err_early_rlast: got %b beats %0d want 1 2", e, rb);
    end
    run_read(32'h600, 1, 0, 0, 5, -1, -1, 0, $urandom, dc, rb, e);
    nchecks++;
    if (e !== 1'b1) begin
      nerrors++; $display("FAIL err_rid: got %b want 1", e);
    end
    run_read(32'h700, 2, 0, 0, MID, -1, -1, 1, $urandom, dc, rb, e);
    nchecks++;
    if (e !== 1'b1 || rb !== 3) begin
      nerrors++; $display("FAIL err_no_rlast: got %b beats %0d want 1 3", e, rb);
    end
    run_write(32'h800, 0, 0, 0, -1, 2'b00, 6, dc, e, l);
    nchecks++;
    if (e !== 1'b1) begin
      nerrors++; $display("FAIL err_bid: got %b want 1", e);
    end
  endtask

  task automatic test_reset_mid();
    int dc, rb;
    logic e;
    @(negedge clk);
    req_valid = 1; req_write = 0; req_addr = 32'h900; req_len = 4'd3;
    ARREADY = 1; RVALID = 0;
    @(negedge clk);
    @(negedge clk);
    RVALID = 1; RDATA = 32'h11; RID = 4'(MID); RRESP = 0; RLAST = 0;
    @(negedge clk);
    RDATA = 32'h22; rst = 1; req_valid = 0;
    #1;
    nchecks++;
    if (rbeat_valid !== 1'b1 || rbeat_data !== 32'h22) begin
      nerrors++;
      $display("FAIL mid_beat2: got %b %h want 1 00000022", rbeat_valid, rbeat_data);
    end
    @(negedge clk);
    rst = 0; RVALID = 0; ARREADY = 0;
    #1;
    nchecks++;
    if ({RREADY, ARVALID, stall, done} !== 4'b0) begin
      nerrors++;
      $display("FAIL mid_rst: got %b want 0000", {RREADY, ARVALID, stall, done});
    end
    repeat (3) begin
      @(negedge clk);
      #1;
      nchecks++;
      if (done !== 1'b0) begin
        nerrors++; $display("FAIL mid_no_done: got %b want 0", done);
      end
    end
    run_read(32'hA00, 3, 0, 1, MID, -1, -1, 0, $urandom, dc, rb, e);
    nchecks++;
    if (e !== 1'b0 || rb !== 4) begin
      nerrors++; $display("FAIL mid_recover: got %b beats %0d want 0 4", e, rb);
    end
  endtask

  task automatic test_back_to_back();
    int dc, rb, l;
    logic e;
    run_write(32'hB00, 3, 1, 1, -1, 2'b10, MID, dc, e, l);
    run_read(32'hC00, 2, 1, 1, MID, -1, -1, 0, $urandom, dc, rb, e);
    nchecks++;
    if (e !== 1'b0) begin
      nerrors++; $display("FAIL b2b_err_carry: got %b want 0", e);
    end
  endtask

  task automatic test_random();
    int len, dc, rb, l, early, bad;
    logic [31:0] addr;
    logic e;
    for (int t = 0; t < 40; t++) begin
      len = $urandom_range(0, 15);
      addr = ($urandom & 32'hFFFFF000) |
             32'($urandom_range(0, 1023 - len) * 4);
      if ($urandom_range(0, 1) == 1) begin
        run_write(addr, len, 1, 1, -1,
                  ($urandom_range(0, 4) == 0) ? 2'b10 : 2'b00,
                  ($urandom_range(0, 7) == 0) ? 3 : MID, dc, e, l);
        nchecks++;
        if (l !== 1) begin
          nerrors++; $display("FAIL rnd_wlast t%0d: got %0d want 1", t, l);
        end
      end else begin
        early = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len) : -1;
        bad = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len) : -1;
        run_read(addr, len, -1, 1,
                 ($urandom_range(0, 7) == 0) ? 5 : MID, early, bad,
                 ($urandom_range(0, 9) == 0), $urandom, dc, rb, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_burst_read();
    test_burst_write();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    test_random();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
